// File: rtl/axil_pkg.sv
// Shared AXI-Lite definitions: response codes
// and the command-master FSM state encoding.
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR_DATA,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    RSP
  } state_t;

endpackage

// File: rtl/axil_cmd_master.sv
// Single-command AXI-Lite master with a per-phase
// timeout. Ports: cmd_* in, rsp_* out, m_axi_* bus.
module axil_cmd_master
  import axil_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_data,
  input  logic [DATA_WIDTH/8-1:0] cmd_strb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_data,
  output logic [1:0]              rsp_resp,
  output logic                    rsp_timeout,
  output logic                    m_axi_aw_valid,
  input  logic                    m_axi_aw_ready,
  output logic [ADDR_WIDTH-1:0]   m_axi_aw_addr,
  output logic [2:0]              m_axi_aw_prot,
  output logic                    m_axi_w_valid,
  input  logic                    m_axi_w_ready,
  output logic [DATA_WIDTH-1:0]   m_axi_w_data,
  output logic [DATA_WIDTH/8-1:0] m_axi_w_strb,
  input  logic                    m_axi_b_valid,
  output logic                    m_axi_b_ready,
  input  logic [1:0]              m_axi_b_resp,
  output logic                    m_axi_ar_valid,
  input  logic                    m_axi_ar_ready,
  output logic [ADDR_WIDTH-1:0]   m_axi_ar_addr,
  output logic [2:0]              m_axi_ar_prot,
  input  logic                    m_axi_r_valid,
  output logic                    m_axi_r_ready,
  input  logic [DATA_WIDTH-1:0]   m_axi_r_data,
  input  logic [1:0]              m_axi_r_resp
);

  localparam int SW = DATA_WIDTH / 8;
  // Counter holds cycles already spent in the
  // phase, so the last allowed cycle is N-1.
  localparam logic [15:0] TO_LAST =
    16'(TIMEOUT_CYCLES - 1);

  state_t r_state;
  state_t w_state_nxt;

  logic [15:0]           r_cnt;
  logic                  r_aw_done;
  logic                  r_w_done;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data;
  logic [SW-1:0]         r_strb;
  logic [DATA_WIDTH-1:0] r_rsp_data;
  logic [1:0]            r_rsp_resp;
  logic                  r_rsp_to;

  logic w_aw_hs, w_w_hs, w_b_hs;
  logic w_ar_hs, w_r_hs;
  logic w_to, w_abort;

  assign cmd_ready      = (r_state == IDLE);
  assign m_axi_aw_valid =
    (r_state == WR_ADDR_DATA) && !r_aw_done;
  assign m_axi_w_valid  =
    (r_state == WR_ADDR_DATA) && !r_w_done;
  assign m_axi_b_ready  = (r_state == WR_RESP);
  assign m_axi_ar_valid = (r_state == RD_ADDR);
  assign m_axi_r_ready  = (r_state == RD_DATA);
  assign rsp_valid      = (r_state == RSP);

  assign m_axi_aw_addr = r_addr;
  assign m_axi_ar_addr = r_addr;
  assign m_axi_w_data  = r_data;
  assign m_axi_w_strb  = r_strb;
  assign m_axi_aw_prot = 3'b000;
  assign m_axi_ar_prot = 3'b000;
  assign rsp_data      = r_rsp_data;
  assign rsp_resp      = r_rsp_resp;
  assign rsp_timeout   = r_rsp_to;

  assign w_aw_hs = m_axi_aw_valid && m_axi_aw_ready;
  assign w_w_hs  = m_axi_w_valid && m_axi_w_ready;
  assign w_b_hs  = m_axi_b_valid && m_axi_b_ready;
  assign w_ar_hs = m_axi_ar_valid && m_axi_ar_ready;
  assign w_r_hs  = m_axi_r_valid && m_axi_r_ready;
  assign w_to    = (r_cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Completing handshakes are tested before the
  // timeout so a late handshake still wins.
  always_comb begin
    w_state_nxt = r_state;
    w_abort     = 1'b0;
    unique case (r_state)
      IDLE:
        if (cmd_valid)
          w_state_nxt = cmd_write ? WR_ADDR_DATA
                                  : RD_ADDR;
      WR_ADDR_DATA:
        if ((r_aw_done || w_aw_hs) &&
            (r_w_done || w_w_hs))
          w_state_nxt = WR_RESP;
        else if (w_to) begin
          w_state_nxt = RSP;
          w_abort     = 1'b1;
        end
      WR_RESP:
        if (w_b_hs) w_state_nxt = RSP;
        else if (w_to) begin
          w_state_nxt = RSP;
          w_abort     = 1'b1;
        end
      RD_ADDR:
        if (w_ar_hs) w_state_nxt = RD_DATA;
        else if (w_to) begin
          w_state_nxt = RSP;
          w_abort     = 1'b1;
        end
      RD_DATA:
        if (w_r_hs) w_state_nxt = RSP;
        else if (w_to) begin
          w_state_nxt = RSP;
          w_abort     = 1'b1;
        end
      RSP:
        if (rsp_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt      <= '0;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
      r_strb     <= '0;
      r_rsp_data <= '0;
      r_rsp_resp <= '0;
      r_rsp_to   <= 1'b0;
    end else begin
      if (w_state_nxt != r_state)
        r_cnt <= '0;
      else if (r_cnt != 16'hFFFF)
        r_cnt <= r_cnt + 16'd1;

      if (w_state_nxt != WR_ADDR_DATA) begin
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end else begin
        if (w_aw_hs) r_aw_done <= 1'b1;
        if (w_w_hs)  r_w_done  <= 1'b1;
      end

      if (cmd_valid && cmd_ready) begin
        r_addr <= cmd_addr;
        r_data <= cmd_data;
        r_strb <= cmd_strb;
      end

      if (w_abort) begin
        r_rsp_data <= '0;
        r_rsp_resp <= RESP_SLVERR;
        r_rsp_to   <= 1'b1;
      end else if (w_b_hs) begin
        r_rsp_data <= '0;
        r_rsp_resp <= m_axi_b_resp;
        r_rsp_to   <= 1'b0;
      end else if (w_r_hs) begin
        r_rsp_data <= m_axi_r_data;
        r_rsp_resp <= m_axi_r_resp;
        r_rsp_to   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axil_cmd_master.sv
// Directed bench for axil_cmd_master: write,
// stalled write, read, timeout, reset abort.
module tb_axil_cmd_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [3:0]  cmd_addr;
  logic [31:0] cmd_data;
  logic [3:0]  cmd_strb;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_resp;
  logic        rsp_timeout;
  logic        aw_valid, aw_ready;
  logic [3:0]  aw_addr;
  logic [2:0]  aw_prot;
  logic        w_valid, w_ready;
  logic [31:0] w_data;
  logic [3:0]  w_strb;
  logic        b_valid, b_ready;
  logic [1:0]  b_resp;
  logic        ar_valid, ar_ready;
  logic [3:0]  ar_addr;
  logic [2:0]  ar_prot;
  logic        r_valid, r_ready;
  logic [31:0] r_data;
  logic [1:0]  r_resp;

  int n_err = 0;
  int n_chk = 0;

  axil_cmd_master #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(4),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_data(cmd_data), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_resp(rsp_resp),
    .rsp_timeout(rsp_timeout),
    .m_axi_aw_valid(aw_valid),
    .m_axi_aw_ready(aw_ready),
    .m_axi_aw_addr(aw_addr),
    .m_axi_aw_prot(aw_prot),
    .m_axi_w_valid(w_valid),
    .m_axi_w_ready(w_ready),
    .m_axi_w_data(w_data),
    .m_axi_w_strb(w_strb),
    .m_axi_b_valid(b_valid),
    .m_axi_b_ready(b_ready),
    .m_axi_b_resp(b_resp),
    .m_axi_ar_valid(ar_valid),
    .m_axi_ar_ready(ar_ready),
    .m_axi_ar_addr(ar_addr),
    .m_axi_ar_prot(ar_prot),
    .m_axi_r_valid(r_valid),
    .m_axi_r_ready(r_ready),
    .m_axi_r_data(r_data),
    .m_axi_r_resp(r_resp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic send(input logic wr,
                      input logic [3:0] a,
                      input logic [31:0] d,
                      input logic [3:0] s);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_data  = d;
    cmd_strb  = s;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("rsp_drop", 32'(rsp_valid), 32'd0);
    check("idle_rdy", 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want done");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    cmd_valid = 0; cmd_write = 0;
    cmd_addr = 0; cmd_data = 0; cmd_strb = 0;
    rsp_ready = 0;
    aw_ready = 0; w_ready = 0;
    b_valid = 0; b_resp = 0;
    ar_ready = 0;
    r_valid = 0; r_data = 0; r_resp = 0;
    tick(); tick();
    reset = 1'b0;
    tick();
    check("rst_cmd_rdy", 32'(cmd_ready), 32'd1);
    check("rst_aw_v", 32'(aw_valid), 32'd0);
    check("rst_w_v", 32'(w_valid), 32'd0);
    check("rst_ar_v", 32'(ar_valid), 32'd0);
    check("rst_b_r", 32'(b_ready), 32'd0);
    check("rst_r_r", 32'(r_ready), 32'd0);
    check("rst_rsp_v", 32'(rsp_valid), 32'd0);
    check("rst_rsp_d", rsp_data, 32'd0);
    check("rst_rsp_to", 32'(rsp_timeout), 32'd0);
    check("rst_w_data", w_data, 32'd0);

    // Write, slave always ready
    aw_ready = 1; w_ready = 1;
    send(1'b1, 4'h1, 32'h00001ABC, 4'hF);
    check("w1_aw_v", 32'(aw_valid), 32'd1);
    check("w1_w_v", 32'(w_valid), 32'd1);
    check("w1_addr", 32'(aw_addr), 32'h1);
    check("w1_data", w_data, 32'h00001ABC);
    check("w1_strb", 32'(w_strb), 32'hF);
    check("w1_prot", 32'(aw_prot), 32'd0);
    check("w1_cmd_r", 32'(cmd_ready), 32'd0);
    tick();
    check("w1_aw_off", 32'(aw_valid), 32'd0);
    check("w1_w_off", 32'(w_valid), 32'd0);
    check("w1_b_r", 32'(b_ready), 32'd1);
    b_valid = 1; b_resp = 2'b00;
    tick();
    b_valid = 0;
    check("w1_rsp_v", 32'(rsp_valid), 32'd1);
    check("w1_resp", 32'(rsp_resp), 32'd0);
    check("w1_to", 32'(rsp_timeout), 32'd0);
    check("w1_b_off", 32'(b_ready), 32'd0);
    finish_rsp();

    // Write with w_ready 3 cycles behind aw
    aw_ready = 1; w_ready = 0;
    send(1'b1, 4'h2, 32'hDEADBEEF, 4'h3);
    check("w2_aw_v", 32'(aw_valid), 32'd1);
    check("w2_w_v", 32'(w_valid), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("w2_aw_drop", 32'(aw_valid), 32'd0);
      check("w2_w_hold", 32'(w_valid), 32'd1);
      check("w2_w_data", w_data, 32'hDEADBEEF);
      check("w2_w_strb", 32'(w_strb), 32'h3);
      if (i == 2) w_ready = 1;
    end
    tick();
    w_ready = 0;
    check("w2_w_off", 32'(w_valid), 32'd0);
    check("w2_b_r", 32'(b_ready), 32'd1);
    b_valid = 1; b_resp = 2'b11;
    tick();
    b_valid = 0;
    check("w2_rsp_v", 32'(rsp_valid), 32'd1);
    check("w2_resp", 32'(rsp_resp), 32'h3);
    check("w2_data0", rsp_data, 32'd0);
    finish_rsp();
    tick();
    check("w2_single", 32'(rsp_valid), 32'd0);

    // Read, 2-cycle r delay, stray b_valid
    ar_ready = 1; b_valid = 1;
    send(1'b0, 4'h0, 32'hFFFFFFFF, 4'h0);
    check("r1_ar_v", 32'(ar_valid), 32'd1);
    check("r1_addr", 32'(ar_addr), 32'h0);
    check("r1_prot", 32'(ar_prot), 32'd0);
    check("r1_b_ign", 32'(b_ready), 32'd0);
    tick();
    check("r1_ar_off", 32'(ar_valid), 32'd0);
    check("r1_r_r", 32'(r_ready), 32'd1);
    tick();
    check("r1_r_r2", 32'(r_ready), 32'd1);
    tick();
    r_valid = 1; r_data = 32'h00000ABC; r_resp = 0;
    tick();
    r_valid = 0; b_valid = 0;
    check("r1_rsp_v", 32'(rsp_valid), 32'd1);
    check("r1_data", rsp_data, 32'h00000ABC);
    check("r1_resp", 32'(rsp_resp), 32'd0);
    check("r1_to", 32'(rsp_timeout), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_v", 32'(rsp_valid), 32'd1);
      check("hold_d", rsp_data, 32'h00000ABC);
      check("hold_cmd", 32'(cmd_ready), 32'd0);
    end
    finish_rsp();

    // Read timeout, ar_ready never rises
    ar_ready = 0;
    send(1'b0, 4'h5, 32'h0, 4'h0);
    for (int i = 0; i < 8; i++) begin
      check("to_ar_v", 32'(ar_valid), 32'd1);
      check("to_addr", 32'(ar_addr), 32'h5);
      tick();
    end
    check("to_ar_off", 32'(ar_valid), 32'd0);
    check("to_r_r", 32'(r_ready), 32'd0);
    check("to_rsp_v", 32'(rsp_valid), 32'd1);
    check("to_flag", 32'(rsp_timeout), 32'd1);
    check("to_resp", 32'(rsp_resp), 32'h2);
    check("to_data", rsp_data, 32'd0);
    finish_rsp();

    // ar handshake on the timeout cycle wins
    send(1'b0, 4'h7, 32'h0, 4'h0);
    for (int i = 0; i < 7; i++) tick();
    ar_ready = 1;
    tick();
    ar_ready = 0;
    check("edge_r_r", 32'(r_ready), 32'd1);
    check("edge_no_rsp", 32'(rsp_valid), 32'd0);
    r_valid = 1; r_data = 32'h00005A5A; r_resp = 1;
    tick();
    r_valid = 0;
    check("edge_rsp_v", 32'(rsp_valid), 32'd1);
    check("edge_to", 32'(rsp_timeout), 32'd0);
    check("edge_data", rsp_data, 32'h00005A5A);
    check("edge_resp", 32'(rsp_resp), 32'h1);
    finish_rsp();

    // Reset during WR_RESP
    aw_ready = 1; w_ready = 1;
    send(1'b1, 4'h9, 32'h12345678, 4'hF);
    tick();
    check("rr_b_r", 32'(b_ready), 32'd1);
    reset = 1'b1;
    tick();
    check("rr_b_off", 32'(b_ready), 32'd0);
    check("rr_aw_v", 32'(aw_valid), 32'd0);
    check("rr_rsp_v", 32'(rsp_valid), 32'd0);
    check("rr_addr", 32'(aw_addr), 32'd0);
    check("rr_wdata", w_data, 32'd0);
    check("rr_rdata", rsp_data, 32'd0);
    check("rr_resp", 32'(rsp_resp), 32'd0);
    reset = 1'b0;
    b_valid = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rr_no_rsp", 32'(rsp_valid), 32'd0);
      check("rr_cmd_r", 32'(cmd_ready), 32'd1);
      check("rr_b_ign", 32'(b_ready), 32'd0);
    end
    b_valid = 0;

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/axil_cmd_master.md
AXIL_CMD_MASTER -- requirements
Module: axil_cmd_master

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, AXI-Lite data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, AXI-Lite address width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, maximum wait per AXI phase before abort (range 1..65535).
REQ-004 SHALL have one clock; reset is synchronous and active-high: clk  in  1  sole clock; reset  in  1  synchronous active-high reset.
REQ-005 cmd_valid  in  1; cmd_ready  out  1; cmd_write  in  1 (1=write, 0=read); cmd_addr  in  ADDR_WIDTH; cmd_data  in  DATA_WIDTH; cmd_strb  in  DATA_WIDTH/8.
REQ-006 rsp_valid  out  1; rsp_ready  in  1; rsp_data  out  DATA_WIDTH (read data, 0 for writes); rsp_resp  out  2 (AXI resp code); rsp_timeout  out  1.
REQ-007 m_axi_aw_valid out 1; m_axi_aw_ready in 1; m_axi_aw_addr out ADDR_WIDTH; m_axi_aw_prot out 3.
REQ-008 m_axi_w_valid out 1; m_axi_w_ready in 1; m_axi_w_data out DATA_WIDTH; m_axi_w_strb out DATA_WIDTH/8.
REQ-009 m_axi_b_valid in 1; m_axi_b_ready out 1; m_axi_b_resp in 2.
REQ-010 m_axi_ar_valid out 1; m_axi_ar_ready in 1; m_axi_ar_addr out ADDR_WIDTH; m_axi_ar_prot out 3; m_axi_r_valid in 1; m_axi_r_ready out 1; m_axi_r_data in DATA_WIDTH; m_axi_r_resp in 2.

Function
REQ-011 SHALL be an FSM with states IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RSP; one transaction outstanding at a time.
REQ-012 cmd_ready SHALL be 1 only in IDLE; cmd_valid&&cmd_ready captures cmd_addr/data/strb/write into registers and moves to WR_ADDR_DATA (write) or RD_ADDR (read) next cycle.
REQ-013 In WR_ADDR_DATA, aw_valid and w_valid SHALL both assert in the first cycle; each SHALL drop in the cycle after its own handshake, independently; state moves to WR_RESP once both handshakes have occurred (same or different cycles).
REQ-014 In WR_RESP, b_ready SHALL be 1; b handshake latches b_resp, sets rsp_data=0, moves to RSP.
REQ-015 In RD_ADDR, ar_valid SHALL be 1 until ar handshake, then RD_DATA; in RD_DATA r_ready SHALL be 1; r handshake latches r_data/r_resp, moves to RSP.
REQ-016 Any valid SHALL NOT depend combinationally on any ready; once asserted, valid and its payload SHALL stay stable until handshake.
REQ-017 aw_prot/ar_prot SHALL be constant 3'b000; addresses passed through unmodified.
REQ-018 In RSP, rsp_valid SHALL be 1 with stable payload; rsp_valid&&rsp_ready returns to IDLE; back-to-back commands therefore cost at least one IDLE cycle.
REQ-019 A per-phase cycle counter SHALL reset on every state entry; if it reaches TIMEOUT_CYCLES in WR_ADDR_DATA, WR_RESP, RD_ADDR or RD_DATA, all AXI valids/readies drop next cycle, and RSP is entered with rsp_timeout=1, rsp_resp=2'b10 (SLVERR), rsp_data=0.
REQ-020 A handshake arriving in the same cycle the counter reaches TIMEOUT_CYCLES SHALL win (normal completion, rsp_timeout=0).
REQ-021 b_valid or r_valid arriving outside WR_RESP/RD_DATA SHALL be ignored (ready low).

Reset
REQ-022 On reset SHALL enter IDLE; all AXI valid/ready outputs 0, rsp_valid 0, rsp_data 0, rsp_resp 0, rsp_timeout 0, address/data/strb outputs 0, counter 0; cmd_ready 1 from first cycle after reset release.
REQ-023 Reset mid-transaction SHALL abandon it with no response emitted.

Structure
REQ-024 Shared package axil_pkg SHALL hold AXI resp constants (OKAY, EXOKAY, SLVERR, DECERR) and the FSM state enum.
REQ-025 Single flat module; no sub-module required.

Verification
REQ-026 Write addr 0x1 data 0x00001ABC strb 0xF, slave ready always -> aw/w handshake same cycle, one b, rsp_resp=0, rsp_timeout=0.
REQ-027 Write with w_ready delayed 3 cycles after aw_ready -> aw_valid drops after its handshake, w_valid held 3 more cycles with stable data, single response.
REQ-028 Read addr 0x0 with slave returning r_data 0x00000ABC after 2-cycle r delay -> rsp_data=0x00000ABC, rsp_resp=0.
REQ-029 TIMEOUT_CYCLES=8, slave never asserts ar_ready -> ar_valid low after 8 cycles, rsp_timeout=1, rsp_resp=2'b10.
REQ-030 rsp_ready held low 5 cycles -> rsp_valid/payload stable, cmd_ready 0 throughout; reset asserted during WR_RESP -> all outputs reset, no rsp_valid.
